// File: rtl/fibonacci_pkg.sv
// Shared definitions for the Fibonacci generator/checker pair: FSM states and sequence seeds.
package fibonacci_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StReport
  } state_e;

  localparam int unsigned FIB_SEED0 = 0;
  localparam int unsigned FIB_SEED1 = 1;

endpackage

// File: rtl/fibonacci_term_gen.sv
// Expected-term source: an (a, b) register pair stepping through the Fibonacci sequence
// modulo 2^WIDTH; a is the current expected term.
module fibonacci_term_gen
  import fibonacci_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  output logic [WIDTH-1:0] term
);

  logic [WIDTH-1:0] a_q, b_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_q <= WIDTH'(FIB_SEED0);
      b_q <= WIDTH'(FIB_SEED1);
    end else if (clear) begin
      a_q <= WIDTH'(FIB_SEED0);
      b_q <= WIDTH'(FIB_SEED1);
    end else if (advance) begin
      a_q <= b_q;
      b_q <= a_q + b_q;
    end
  end

  assign term = a_q;

endmodule

// File: rtl/fibonacci_checker.sv
// Checks a valid/ready stream of terms against the Fibonacci sequence and reports the result.
// Define FIB_CHECKER_STOP_ON_ERROR_EN to end a run at the first mismatching term.
module fibonacci_checker
  import fibonacci_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] err_index,
  output logic [WIDTH-1:0] match_count
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] match_q, match_d;
  logic [WIDTH-1:0] err_q, err_d;
  logic             pass_q, pass_d;

  logic             accept;
  logic             handshake;
  logic             hit;
  logic             last;
  logic [WIDTH-1:0] expected;

  assign accept    = (state_q == StIdle) && start;
  assign handshake = (state_q == StCheck) && in_valid;
  assign hit       = (in_data == expected);
  // n_q is nonzero whenever CHECK is entered, so n_q - 1 cannot underflow here.
  assign last      = (idx_q == n_q - WIDTH'(1));

  fibonacci_term_gen #(
    .WIDTH(WIDTH)
  ) u_term_gen (
    .clock  (clock),
    .reset  (reset),
    .clear  (accept),
    .advance(handshake),
    .term   (expected)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    match_d = match_q;
    err_d   = err_q;
    pass_d  = pass_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          n_d     = n;
          idx_d   = '0;
          match_d = '0;
          err_d   = '0;
          pass_d  = 1'b1;
          state_d = (n == '0) ? StReport : StCheck;
        end
      end
      StCheck: begin
        if (in_valid) begin
          idx_d = idx_q + WIDTH'(1);
          if (hit) begin
            match_d = match_q + WIDTH'(1);
          end else if (pass_q) begin
            err_d  = idx_q;
            pass_d = 1'b0;
          end
          if (last) state_d = StReport;
`ifdef FIB_CHECKER_STOP_ON_ERROR_EN
          if (!hit) state_d = StReport;
`endif
        end
      end
      StReport: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      n_q     <= '0;
      idx_q   <= '0;
      match_q <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      match_q <= match_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end

  assign in_ready    = (state_q == StCheck);
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StReport);
  assign pass        = pass_q;
  assign err_index   = err_q;
  assign match_count = match_q;

endmodule
